controle_varredura_disp: RTL

//  Time-multiplexed scan controller for the shared 7-segment decoder. Holds NUM_DIG 5-bit digit codes
//  {TOM,A,B,C,D}, drives the decoder inputs and a one-hot digit enable. A blanking gap between digits

---
 rtl/controle_varredura_disp.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/controle_varredura_disp.sv
// Scan controller for a shared 7-segment decoder: blank/show per digit,
// shadow codes copied to the active set only at frame wrap.
module controle_varredura_disp #(
  parameter int NUM_DIG   = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_DIG)-1:0] wr_addr,
  input  logic [4:0]                 wr_data,
  input  logic                       commit,
  output logic                       commit_pend,
  output logic                       frame_done,
  output logic                       dec_tom,
  output logic                       dec_a,
  output logic                       dec_b,
  output logic                       dec_c,
  output logic                       dec_d,
  output logic [NUM_DIG-1:0]         dig_en
);

  localparam int AW   = $clog2(NUM_DIG);
  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] ONE = NUM_DIG'(1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t        state, st_n;
  logic [AW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          fd_n;
  logic          copy;
  logic          wr_ok;

  logic [NUM_DIG-1:0] en_n;
  logic [4:0]         code_n;

  logic [4:0] shadow [NUM_DIG];
  logic [4:0] active [NUM_DIG];

  always_comb begin
    st_n  = state;
    idx_n = idx;
    cnt_n = cnt;
    fd_n  = 1'b0;
    if (!enable) begin
      st_n  = IDLE;
      idx_n = '0;
      cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          st_n  = BLANK;
          idx_n = '0;
          cnt_n = '0;
        end
        BLANK: begin
          if (cnt == BL_LAST) begin
            st_n  = SHOW;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == DW_LAST) begin
            st_n  = BLANK;
            cnt_n = '0;
            // Leaving the last digit closes the frame.
            if (idx == IDX_LAST) begin
              idx_n = '0;
              fd_n  = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          st_n  = IDLE;
          idx_n = '0;
          cnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    copy   = commit_pend & (fd_n | (state == IDLE));
    wr_ok  = wr_en & (int'(wr_addr) < NUM_DIG);
    en_n   = (st_n == SHOW) ? (ONE << idx_n) : '0;
    // Decoder must see the freshly copied code on the copy edge.
    code_n = copy ? shadow[idx_n] : active[idx_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      commit_pend <= 1'b0;
      frame_done  <= 1'b0;
      dig_en      <= '0;
      dec_tom     <= 1'b0;
      dec_a       <= 1'b0;
      dec_b       <= 1'b0;
      dec_c       <= 1'b0;
      dec_d       <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state      <= st_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      frame_done <= fd_n;
      dig_en     <= en_n;
      {dec_tom, dec_a, dec_b, dec_c, dec_d} <= code_n;
      commit_pend <= copy ? 1'b0 : (commit_pend | commit);
      if (wr_ok)
        shadow[wr_addr] <= wr_data;
      if (copy) begin
        for (int i = 0; i < NUM_DIG; i++)
          active[i] <= shadow[i];
      end
    end
  end

endmodule
